pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side counterpart to the input debouncer. It converts single-cycle event pulses from the fabric into human-visible LED blinks of fixed length, with a guaranteed dark gap between blinks. Rapid events are queued per channel, up to a saturating limit, so that each one produces a distinct blink. It sits between the core logic and the board LEDs and uses the same tick-prescaler scheme as the input conditioning path.

## Interface
- WIDTH, 1: number of independent channels.
- TICK_CNT_MAX, 62500: clock cycles per prescaler tick; must be ≥ 2.
- ON_TICKS, 200: blink length in ticks; must be ≥ 1.
- GAP_TICKS, 50: dark gap after each blink, in ticks; must be ≥ 1.
- PEND_MAX, 3: maximum number of queued events per channel; must be ≥ 1.
- TICK_CNT_WIDTH, $clog2(TICK_CNT_MAX): prescaler counter width.
- DUR_CNT_WIDTH, $clog2(max(ON_TICKS,GAP_TICKS))+1: per-channel duration counter width.
- PEND_WIDTH, $clog2(PEND_MAX)+1: per-channel pending counter width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- event_pulse  input  WIDTH  each cycle a bit is high counts as one event on that channel.
- stretched  output  WIDTH  registered LED drive, high during a blink.
- busy  output  WIDTH  high when the channel state is not IDLE or its pending count is non-zero; decoded from registers.

## Operation
- Prescaler:
  - Shared wrapping counter 0..TICK_CNT_MAX-1.
  - Registered `tick` is high for one cycle in the cycle after the counter equals TICK_CNT_MAX-1.
- Per-channel FSM with states IDLE, ON and GAP, plus a duration counter `dur` and a pending counter `pend`.
- IDLE (stretched=0):
  - Event high → ON next cycle, dur←ON_TICKS.
  - pend is always 0 while in IDLE.
- ON (stretched=1):
  - On a tick with dur>1: dur←dur-1.
  - On a tick with dur==1: → GAP, dur←GAP_TICKS.
  - Each event while in ON: pend←min(pend+1, PEND_MAX).
- GAP (stretched=0):
  - On a tick with dur>1: dur←dur-1.
  - On a tick with dur==1 and pend>0: → ON directly, dur←ON_TICKS, pend decremented.
  - On a tick with dur==1 and pend==0: → IDLE.
  - Events while in GAP are counted into pend, saturating at PEND_MAX.
- Simultaneous event and expiry:
  - The event is counted first, then the transition is evaluated on the updated count.
  - Example: GAP expiry with pend==0 and a simultaneous event → ON with pend=0.
  - Example: pend==PEND_MAX at GAP expiry with a simultaneous event → pend stays PEND_MAX-1 (saturation applies before the decrement).
- Events beyond saturation are dropped silently.
- Channels are fully independent and share only the tick.
- Reset (asynchronous, any time including mid-blink): prescaler=0, tick=0, all channels IDLE, dur=0, pend=0, stretched=0, busy=0.

## Timing
- Latency from an event in IDLE to stretched high: 1 cycle (event sampled at edge N, stretched high from N+1).
- Blink length: (ON_TICKS-1)·TICK_CNT_MAX+1 to ON_TICKS·TICK_CNT_MAX cycles, depending on tick phase.
- Gap length: (GAP_TICKS-1)·TICK_CNT_MAX+1 to GAP_TICKS·TICK_CNT_MAX cycles.
- stretched falls in the cycle after the expiring tick.
- A queued blink rises in the cycle after the GAP-expiring tick.
- Tick schedule: after reset release at cycle 0, the first tick is at cycle TICK_CNT_MAX, then every TICK_CNT_MAX cycles.
- All outputs are registered or decoded from registers, so there is no combinational path from event_pulse to any output.

## Test plan
Parameters for scenarios 1–5: TICK_CNT_MAX=4, ON_TICKS=3, GAP_TICKS=2, PEND_MAX=2, WIDTH=2. Ticks therefore fall at cycles 4, 8, 12, …

1. Single event on ch0 at cycle 5 → stretched[0] high cycles 6–16 (11 cycles), busy[0] low from cycle 25; ch1 stays 0 throughout.
2. ch0 events at cycles 5, 6 and 7 → blinks at cycles 6–16, 25–36 and 45–56; busy[0] low from cycle 65.
3. event_pulse[0] held high for cycles 5–14 → exactly 3 blinks, identical to scenario 2 (saturation at pend=2).
4. Event at cycle 5, rst_n asserted low at cycle 10 mid-blink → stretched and busy drop immediately (asynchronously). After release, the next event blinks normally with a 1-cycle latency, and the tick phase restarts at release.
5. Simultaneous events on ch0 at cycle 5 and on ch1 at cycle 13 → ch0 high cycles 6–16, ch1 high cycles 14–24; each channel's gap ends independently.
6. Event arriving in the same cycle as the GAP-expiring tick (cycle 24 after scenario 1) → stretched rises at cycle 25 and pend ends at 0.

Source files
------------

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into fixed-length LED
// blinks separated by a guaranteed dark gap. Events arriving during a blink
// or gap are queued per channel (saturating), each producing its own blink.
// All channels share one tick prescaler; everything else is per channel.
module pulse_stretcher #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned TICK_CNT_MAX   = 62500,
  parameter int unsigned ON_TICKS       = 200,
  parameter int unsigned GAP_TICKS      = 50,
  parameter int unsigned PEND_MAX       = 3,
  parameter int unsigned TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX),
  parameter int unsigned DUR_CNT_WIDTH  =
    $clog2((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) + 1,
  parameter int unsigned PEND_WIDTH     = $clog2(PEND_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] event_pulse,
  output logic [WIDTH-1:0] stretched,
  output logic [WIDTH-1:0] busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST  = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);
  localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE   = TICK_CNT_WIDTH'(1);
  localparam logic [DUR_CNT_WIDTH-1:0]  DUR_ON     = DUR_CNT_WIDTH'(ON_TICKS);
  localparam logic [DUR_CNT_WIDTH-1:0]  DUR_GAP    = DUR_CNT_WIDTH'(GAP_TICKS);
  localparam logic [DUR_CNT_WIDTH-1:0]  DUR_ONE    = DUR_CNT_WIDTH'(1);
  localparam logic [PEND_WIDTH-1:0]     PEND_LIMIT = PEND_WIDTH'(PEND_MAX);
  localparam logic [PEND_WIDTH-1:0]     PEND_ONE   = PEND_WIDTH'(1);

  // Shared prescaler
  logic [TICK_CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                      tick_q, tick_d;

  // Per-channel state
  state_e                   state_q [WIDTH];
  state_e                   state_d [WIDTH];
  logic [DUR_CNT_WIDTH-1:0] dur_q   [WIDTH];
  logic [DUR_CNT_WIDTH-1:0] dur_d   [WIDTH];
  logic [PEND_WIDTH-1:0]    pend_q  [WIDTH];
  logic [PEND_WIDTH-1:0]    pend_d  [WIDTH];
  logic [WIDTH-1:0]         stretched_q, stretched_d;

  // Prescaler next state: wrap at TICK_CNT_MAX-1 and flag the wrap as a tick
  always_comb begin
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TICK_ONE;
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // Per-channel next state: the event is folded into the pending count first,
  // and a GAP expiry then consumes from that updated (saturated) count.
  always_comb begin
    logic [PEND_WIDTH-1:0] pend_cnt;
    pend_cnt    = '0;
    stretched_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      dur_d[i]   = dur_q[i];
      pend_d[i]  = pend_q[i];

      pend_cnt = pend_q[i];
      if (event_pulse[i] && (pend_q[i] < PEND_LIMIT)) begin
        pend_cnt = pend_q[i] + PEND_ONE;
      end

      unique case (state_q[i])
        S_IDLE: begin
          if (event_pulse[i]) begin
            state_d[i] = S_ON;
            dur_d[i]   = DUR_ON;
          end
        end
        S_ON: begin
          pend_d[i] = pend_cnt;
          if (tick_q) begin
            if (dur_q[i] == DUR_ONE) begin
              state_d[i] = S_GAP;
              dur_d[i]   = DUR_GAP;
            end else begin
              dur_d[i] = dur_q[i] - DUR_ONE;
            end
          end
        end
        S_GAP: begin
          pend_d[i] = pend_cnt;
          if (tick_q) begin
            if (dur_q[i] == DUR_ONE) begin
              if (pend_cnt != '0) begin
                state_d[i] = S_ON;
                dur_d[i]   = DUR_ON;
                pend_d[i]  = pend_cnt - PEND_ONE;
              end else begin
                state_d[i] = S_IDLE;
                dur_d[i]   = '0;
              end
            end else begin
              dur_d[i] = dur_q[i] - DUR_ONE;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          dur_d[i]   = '0;
          pend_d[i]  = '0;
        end
      endcase

      stretched_d[i] = (state_d[i] == S_ON);
    end
  end

  // Per-channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= S_IDLE;
        dur_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      stretched_q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        dur_q[i]   <= dur_d[i];
        pend_q[i]  <= pend_d[i];
      end
      stretched_q <= stretched_d;
    end
  end

  // Busy decode: any channel not idle or still holding queued events
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      busy[i] = (state_q[i] != S_IDLE) || (pend_q[i] != '0);
    end
  end

  assign stretched = stretched_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scenario bench with TICK_CNT_MAX=4, ON_TICKS=3,
// GAP_TICKS=2, PEND_MAX=2, WIDTH=2. Expected per-cycle {busy, stretched}
// words are derived from blink/busy intervals and queued per scenario.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] event_pulse = '0;
  logic [1:0] stretched;
  logic [1:0] busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;
  string scen  = "init";

  logic [3:0]   sb_q [$];
  logic [127:0] ev0_m, ev1_m;
  int bs0 [3];
  int be0 [3];
  int bb0s, bb0e, bs1, be1, bb1s, bb1e;

  pulse_stretcher #(
    .WIDTH       (2),
    .TICK_CNT_MAX(4),
    .ON_TICKS    (3),
    .GAP_TICKS   (2),
    .PEND_MAX    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .event_pulse(event_pulse),
    .stretched  (stretched),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired scen=%s cyc=%0d", scen, cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s cyc=%0d got=%0h exp=%0h", scen, tag, cyc, got, exp);
    end
  endtask

  task automatic clear_exp();
    ev0_m = '0;
    ev1_m = '0;
    bs0   = '{-1, -1, -1};
    be0   = '{-2, -2, -2};
    bb0s  = -1; bb0e = -2;
    bs1   = -1; be1  = -2;
    bb1s  = -1; bb1e = -2;
  endtask

  // Assert reset at a falling edge, check the reset state, release mid-cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    event_pulse = '0;
    #1;
    cyc = -1;
    check_eq("rst_stretched", stretched, 0);
    check_eq("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Queue expectations for n cycles, then drive events and compare per cycle.
  task automatic run(input int n);
    logic       s0, s1, b0, b1;
    logic [3:0] e;
    for (int c = 0; c < n; c++) begin
      s0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (c >= bs0[k] && c <= be0[k]) s0 = 1'b1;
      end
      s1 = (c >= bs1  && c <= be1);
      b0 = (c >= bb0s && c <= bb0e);
      b1 = (c >= bb1s && c <= bb1e);
      sb_q.push_back({b1, b0, s1, s0});
    end
    for (int c = 0; c < n; c++) begin
      cyc         = c;
      event_pulse = {ev1_m[c], ev0_m[c]};
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL %s scoreboard_empty cyc=%0d", scen, c);
      end else begin
        e = sb_q.pop_front();
        check_eq("stretched", stretched, e[1:0]);
        check_eq("busy", busy, e[3:2]);
      end
      @(negedge clk);
    end
    event_pulse = '0;
  endtask

  initial begin
    // Single event on ch0
    scen = "s1"; clear_exp();
    ev0_m[5] = 1'b1;
    bs0[0] = 6; be0[0] = 16; bb0s = 6; bb0e = 24;
    do_reset(); run(30);

    // Three back-to-back events queue two extra blinks
    scen = "s2"; clear_exp();
    ev0_m[5] = 1'b1; ev0_m[6] = 1'b1; ev0_m[7] = 1'b1;
    bs0 = '{6, 25, 45}; be0 = '{16, 36, 56}; bb0s = 6; bb0e = 64;
    do_reset(); run(70);

    // Held event saturates the pending count at 2
    scen = "s3"; clear_exp();
    for (int c = 5; c <= 14; c++) ev0_m[c] = 1'b1;
    bs0 = '{6, 25, 45}; be0 = '{16, 36, 56}; bb0s = 6; bb0e = 64;
    do_reset(); run(70);

    // Asynchronous reset mid-blink, then a normal blink with restarted phase
    scen = "s4"; clear_exp();
    ev0_m[5] = 1'b1;
    bs0[0] = 6; be0[0] = 16; bb0s = 6; bb0e = 24;
    do_reset(); run(10);
    cyc = 10;
    check_eq("pre_rst_stretched", stretched, 2'b01);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_stretched", stretched, 0);
    check_eq("async_rst_busy", busy, 0);
    scen = "s4b";
    do_reset(); run(30);

    // Independent channels
    scen = "s5"; clear_exp();
    ev0_m[5] = 1'b1; ev1_m[13] = 1'b1;
    bs0[0] = 6; be0[0] = 16; bb0s = 6; bb0e = 24;
    bs1 = 14; be1 = 24; bb1s = 14; bb1e = 32;
    do_reset(); run(40);

    // Event coincident with the GAP-expiring tick: one extra blink only
    scen = "s6"; clear_exp();
    ev0_m[5] = 1'b1; ev0_m[24] = 1'b1;
    bs0[0] = 6; be0[0] = 16; bs0[1] = 25; be0[1] = 36; bb0s = 6; bb0e = 44;
    do_reset(); run(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
